// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port (ALU vs LSU, round-robin)
// plus the pending-write busy bitmap that decode uses for read-after-write stalls.
module rf_wb_arbiter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   output logic            alu_ready,
   input  logic            lsu_valid,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   output logic            lsu_ready,
   input  logic            wb_stall,
   input  logic            iss_valid,
   input  logic [4:0]      iss_rd,
   output logic            we3,
   output logic [4:0]      a3,
   output logic [XLEN-1:0] wd3,
   output logic [31:0]     busy
);

   typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_e;

   src_e            last_q, last_d;
   logic            we3_q, we3_d;
   logic [4:0]      a3_q, a3_d;
   logic [XLEN-1:0] wd3_q, wd3_d;
   logic [31:0]     busy_q, busy_d;

   // Round-robin grant: on a tie the requester that did not win last time goes.
   always_comb begin
      alu_ready = 1'b0;
      lsu_ready = 1'b0;
      if (!rst && !wb_stall) begin
         if (alu_valid && lsu_valid) begin
            if (last_q == SRC_LSU) alu_ready = 1'b1;
            else                   lsu_ready = 1'b1;
         end else begin
            alu_ready = alu_valid;
            lsu_ready = lsu_valid;
         end
      end
   end

   always_comb begin
      we3_d  = 1'b0;
      a3_d   = a3_q;
      wd3_d  = wd3_q;
      last_d = last_q;
      if (alu_ready) begin
         we3_d  = (alu_rd != 5'd0);
         a3_d   = alu_rd;
         wd3_d  = alu_data;
         last_d = SRC_ALU;
      end else if (lsu_ready) begin
         we3_d  = (lsu_rd != 5'd0);
         a3_d   = lsu_rd;
         wd3_d  = lsu_data;
         last_d = SRC_LSU;
      end
   end

   // Clear on the committing write, then set on issue so a same-edge re-issue keeps the bit.
   always_comb begin
      busy_d = busy_q;
      if (we3_q) busy_d[a3_q] = 1'b0;
      if (iss_valid && (iss_rd != 5'd0)) busy_d[iss_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= SRC_LSU;
         we3_q  <= 1'b0;
         a3_q   <= '0;
         wd3_q  <= '0;
         busy_q <= '0;
      end else begin
         last_q <= last_d;
         we3_q  <= we3_d;
         a3_q   <= a3_d;
         wd3_q  <= wd3_d;
         busy_q <= busy_d;
      end
   end

   assign we3  = we3_q;
   assign a3   = a3_q;
   assign wd3  = wd3_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios with literal expectations, then
// randomized requesters, all checked every cycle against a behavioural model.
module tb_rf_wb_arbiter;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            alu_valid, lsu_valid, wb_stall, iss_valid;
   logic [4:0]      alu_rd, lsu_rd, iss_rd;
   logic [XLEN-1:0] alu_data, lsu_data;
   logic            alu_ready, lsu_ready, we3;
   logic [4:0]      a3;
   logic [XLEN-1:0] wd3;
   logic [31:0]     busy;

   rf_wb_arbiter #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .wb_stall(wb_stall), .iss_valid(iss_valid), .iss_rd(iss_rd),
      .we3(we3), .a3(a3), .wd3(wd3), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model state
   bit              m_last_alu;   // 1: most recent grant went to the ALU
   bit              m_we;
   logic [4:0]      m_a3;
   logic [XLEN-1:0] m_wd;
   logic [31:0]     m_busy;
   bit              g_alu, g_lsu;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_last_alu = 1'b0;
      m_we       = 1'b0;
      m_a3       = '0;
      m_wd       = '0;
      m_busy     = '0;
   endtask

   // Let combinational outputs settle, work out who must be granted, compare everything.
   task automatic settle();
      #2;
      g_alu = 1'b0;
      g_lsu = 1'b0;
      if (!rst && !wb_stall) begin
         if (alu_valid && lsu_valid) begin
            if (m_last_alu) g_lsu = 1'b1;
            else            g_alu = 1'b1;
         end else begin
            g_alu = alu_valid;
            g_lsu = lsu_valid;
         end
      end
      chk("alu_ready", 64'(alu_ready), 64'(g_alu));
      chk("lsu_ready", 64'(lsu_ready), 64'(g_lsu));
      chk("we3",       64'(we3),       64'(m_we));
      chk("a3",        64'(a3),        64'(m_a3));
      chk("wd3",       64'(wd3),       64'(m_wd));
      chk("busy",      64'(busy),      64'(m_busy));
   endtask

   // Advance the model across the coming edge, then the clock itself.
   task automatic adv();
      logic [31:0] nb;
      if (rst) begin
         model_reset();
      end else begin
         nb = m_busy;
         if (m_we) nb[m_a3] = 1'b0;
         if (iss_valid && iss_rd != 5'd0) nb[iss_rd] = 1'b1;
         m_busy = nb;
         if (g_alu) begin
            m_we = (alu_rd != 5'd0); m_a3 = alu_rd; m_wd = alu_data; m_last_alu = 1'b1;
         end else if (g_lsu) begin
            m_we = (lsu_rd != 5'd0); m_a3 = lsu_rd; m_wd = lsu_data; m_last_alu = 1'b0;
         end else begin
            m_we = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0; wb_stall = 1'b0; iss_valid = 1'b0;
      alu_rd = '0; lsu_rd = '0; iss_rd = '0; alu_data = '0; lsu_data = '0;
   endtask

   bit              alu_pend, lsu_pend;
   logic [31:0]     saved_busy;

   initial begin
      idle_inputs();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      model_reset();

      // Reset state
      settle();
      chk("rst_we3", 64'(we3), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_a3", 64'(a3), 64'd0);
      adv();
      rst = 1'b0;

      // Single ALU write
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      settle();
      chk("single_ready", 64'(alu_ready), 64'd1);
      adv();
      alu_valid = 1'b0;
      settle();
      chk("single_we3", 64'(we3), 64'd1);
      chk("single_a3", 64'(a3), 64'd5);
      chk("single_wd3", 64'(wd3), 64'hDEADBEEF);
      adv();
      settle();
      chk("single_we3_off", 64'(we3), 64'd0);
      adv();

      // Build up some state, then reset mid-stream with both requesters valid
      iss_valid = 1'b1; iss_rd = 5'd9;
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1111;
      settle(); adv();
      iss_valid = 1'b0;
      rst = 1'b1; alu_valid = 1'b1; lsu_valid = 1'b1;
      alu_rd = 5'd1; lsu_rd = 5'd2; alu_data = 32'hA0; lsu_data = 32'hB0;
      settle();
      chk("rst_no_ready", 64'({alu_ready, lsu_ready}), 64'd0);
      adv();
      rst = 1'b0;

      // Contention: ALU, LSU, ALU, LSU after reset release
      for (int k = 0; k < 5; k++) begin
         alu_valid = (k < 4); lsu_valid = (k < 4);
         alu_data = 32'hA0 + k; lsu_data = 32'hB0 + k;
         settle();
         if (k == 0) begin
            chk("midrst_we3", 64'(we3), 64'd0);
            chk("midrst_busy", 64'(busy), 64'd0);
         end
         if (k < 4) begin
            chk("cont_alu_ready", 64'(alu_ready), 64'((k % 2) == 0));
            chk("cont_lsu_ready", 64'(lsu_ready), 64'((k % 2) == 1));
         end
         if (k > 0) chk("cont_a3", 64'(a3), ((k % 2) == 1) ? 64'd1 : 64'd2);
         adv();
      end
      idle_inputs();

      // Scoreboard: set, clear, and same-edge set over clear
      for (int round = 0; round < 2; round++) begin
         iss_valid = 1'b1; iss_rd = 5'd7;
         settle(); adv();
         iss_valid = 1'b0;
         settle();
         chk("sb_set", 64'(busy[7]), 64'd1);
         adv();
         lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hC0DE0000 + round;
         settle();
         chk("sb_lsu_ready", 64'(lsu_ready), 64'd1);
         adv();
         lsu_valid = 1'b0;
         iss_valid = (round == 1); iss_rd = 5'd7;
         settle();
         chk("sb_we3_a3", 64'({we3, a3}), 64'({1'b1, 5'd7}));
         adv();
         iss_valid = 1'b0;
         settle();
         chk("sb_after", 64'(busy[7]), (round == 1) ? 64'd1 : 64'd0);
         adv();
      end

      // x0 write: accepted, no we3, busy untouched, pointer moves to ALU
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h5555;
      settle();
      chk("x0_ready", 64'(alu_ready), 64'd1);
      saved_busy = busy;
      adv();
      alu_valid = 1'b1; alu_rd = 5'd4; lsu_valid = 1'b1; lsu_rd = 5'd6;
      settle();
      chk("x0_we3", 64'(we3), 64'd0);
      chk("x0_busy", 64'(busy), 64'(saved_busy));
      chk("x0_tie_lsu", 64'(lsu_ready), 64'd1);
      adv();
      idle_inputs();

      // Stall holds the LSU off for three cycles
      wb_stall = 1'b1; lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'hFACE;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("stall_lsu_ready", 64'(lsu_ready), 64'd0);
         adv();
      end
      wb_stall = 1'b0;
      settle();
      chk("stall_release", 64'(lsu_ready), 64'd1);
      adv();
      idle_inputs();

      // Randomized traffic
      alu_pend = 1'b0; lsu_pend = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (!alu_pend && $urandom_range(0, 2) != 0) begin
            alu_pend = 1'b1;
            alu_rd   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            alu_data = $urandom;
         end
         if (!lsu_pend && $urandom_range(0, 2) != 0) begin
            lsu_pend = 1'b1;
            lsu_rd   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            lsu_data = $urandom;
         end
         alu_valid = alu_pend;
         lsu_valid = lsu_pend;
         wb_stall  = ($urandom_range(0, 5) == 0);
         rst       = ($urandom_range(0, 149) == 0);
         iss_valid = ($urandom_range(0, 1) == 0);
         iss_rd    = 5'($urandom_range(0, 31));
         settle();
         if (g_alu) alu_pend = 1'b0;
         if (g_lsu) lsu_pend = 1'b0;
         adv();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and pending-write scoreboard for the integer register file. It shares the file's single write port (`we3`/`a3`/`wd3`) between the ALU and the load/store unit using valid/ready handshakes and round-robin arbitration, and drives that port from registers. It also keeps a per-register busy bitmap: issue sets a bit and the committed write clears it, so decode can stall on read-after-write hazards.

## Interface

Parameters:
- `XLEN`, 32, data width of write-back values and of `wd3`.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `alu_valid`  input  1  ALU has a result to write back.
- `alu_rd`  input  5  ALU destination register.
- `alu_data`  input  XLEN  ALU result.
- `alu_ready`  output  1  ALU result accepted this cycle (combinational).
- `lsu_valid`  input  1  LSU has load data to write back.
- `lsu_rd`  input  5  LSU destination register.
- `lsu_data`  input  XLEN  load data.
- `lsu_ready`  output  1  LSU data accepted this cycle (combinational).
- `wb_stall`  input  1  blocks all grants this cycle.
- `iss_valid`  input  1  an instruction with a destination register issues this cycle.
- `iss_rd`  input  5  destination register of the issuing instruction.
- `we3`  output  1  register file write enable (registered).
- `a3`  output  5  register file write address (registered).
- `wd3`  output  XLEN  register file write data (registered).
- `busy`  output  32  pending-write bitmap; `busy[0]` is always 0.

## Operation

- **Handshake.**
  - A transfer occurs when `valid && ready` at a rising edge.
  - A requester holds `valid`, `rd` and `data` stable until it is accepted.
  - At most one of `alu_ready`/`lsu_ready` is high in any cycle.
  - Both ready outputs are 0 while `wb_stall=1` or `rst=1`.
- **Arbitration.**
  - Only one requester valid: it is granted.
  - Both valid: the requester not granted last is granted.
  - A 1-bit `last` pointer records the requester of every grant.
  - Reset value of `last` is LSU, so the ALU wins the first tie.
- **Write port.**
  - On a grant, the next edge loads `a3`/`wd3` from the winner.
  - `we3` is set to 1 if the winner's rd is nonzero, else 0.
  - No grant: `we3` becomes 0; `a3`/`wd3` hold their previous values.
- **x0 writes.** They are accepted normally (ready asserted, pointer updated) but never raise `we3` and never touch `busy`.
- **Scoreboard.**
  - `busy[r]` is set at the edge where `iss_valid && iss_rd==r && r!=0`.
  - `busy[r]` is cleared at the edge where `we3 && a3==r` is sampled, the same edge the register file captures the data.
  - Set and clear of the same r on the same edge: set wins and the bit stays 1.
  - Decode reads the register file only when `busy` is 0, so it never sees stale data.
- **Reset.**
  - Outputs: `we3=0`, `a3=0`, `wd3=0`, `busy=0`.
  - Internal state: `last`=LSU.
  - Reset overrides any in-flight grant or issue.

## Timing

- Grant to register-file write is 1 cycle:
  - ready is high in cycle N;
  - `we3`/`a3`/`wd3` are valid in N+1;
  - the register file captures at the end of N+1;
  - `busy[r]` reads 0 from N+2.
- Sustained throughput is one write per cycle. With both requesters continuously valid, grants alternate ALU, LSU, ALU, …
- `wb_stall` takes effect in the same cycle (ready drops combinationally). A write already registered in `we3` still completes.
- `busy` updates one edge after `iss_valid` and is visible to decode in the following cycle.

## Test plan

- **Reset.** Assert `rst` mid-stream with both requesters valid → next cycle `we3=0`, `busy=0`. First tie after release grants ALU.
- **Single ALU write.** `alu_valid=1`, `alu_rd=5`, `alu_data=0xDEADBEEF` in cycle N → `alu_ready=1` in N; `we3=1`, `a3=5`, `wd3=0xDEADBEEF` in N+1; `we3=0` in N+2.
- **Contention.** Both valid continuously for 4 cycles, `alu_rd=1`, `lsu_rd=2` → grants ALU, LSU, ALU, LSU. `a3` sequence in the following cycles is 1, 2, 1, 2; never two readies in the same cycle.
- **Scoreboard.**
  - Issue rd=7 → `busy[7]=1` next cycle.
  - LSU writes rd=7 → `busy[7]` clears the edge after `we3` with `a3=7`.
  - Issue rd=7 again on that same edge → `busy[7]` stays 1.
- **x0 and stall.**
  - `alu_rd=0` → accepted, `we3` stays 0, `busy` unchanged.
  - `wb_stall=1` with `lsu_valid=1` for 3 cycles → `lsu_ready=0` throughout; granted in the first cycle after stall drops.
